video_pattern_sequencer: RTL

- Frame-synchronous controller that selects which test pattern the downstream colour-bar/pattern generator drives on the HDMI output.
- Advances the pattern automatically after a programmable number of frames, or manually on a request/acknowledge handshake, e.g. from a debounced key.
- Pattern changes take effect only on a frame boundary, so no frame ever shows mixed patterns.
- Sits between the timing driver (frame_start pulse) and the pixel generator (pattern_sel).

---
 rtl/video_pattern_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/video_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// video_pattern_sequencer
//
// Purpose:
//   Frame-synchronous selector for the test pattern that the downstream
//   pattern generator drives on the video output. The pattern advances
//   automatically after HOLD_FRAMES frames when auto_en is high. It can also
//   advance manually through a next_req / next_ack handshake. Every pattern
//   change lands on a frame_start edge, so a frame never mixes two patterns.
//
// Parameters:
//   NUM_PATTERNS - number of patterns; pattern_sel wraps 0..NUM_PATTERNS-1 (2..8)
//   HOLD_FRAMES  - frames per pattern in auto mode (1..255)
//   CNT_W        - width of frame_cnt; 2**CNT_W must exceed HOLD_FRAMES
//
// Ports:
//   pixel_clk      in   pixel clock; all state changes on its rising edge
//   rst            in   synchronous, active-high reset
//   frame_start    in   one-cycle pulse at the first active pixel of a frame
//   auto_en        in   level; 1 = advance every HOLD_FRAMES frames
//   next_req       in   manual advance request, held by requester until ack
//   next_ack       out  one-cycle pulse: request accepted
//   pattern_sel    out  current pattern index
//   pattern_switch out  one-cycle pulse in the cycle pattern_sel changes
//   frame_cnt      out  frames elapsed in the current pattern
//   busy           out  high while an accepted manual advance is pending
// ---------------------------------------------------------------------------
module video_pattern_sequencer #(
  parameter int NUM_PATTERNS = 5,
  parameter int HOLD_FRAMES  = 60,
  parameter int CNT_W        = 8
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             auto_en,
  input  logic             next_req,
  output logic             next_ack,
  output logic [2:0]       pattern_sel,
  output logic             pattern_switch,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,  // waiting for the first frame boundary
    S_RUN  = 2'd1,  // normal operation
    S_PEND = 2'd2   // manual advance accepted, waiting for a frame boundary
  } state_e;

  localparam logic [2:0]       LAST_SEL  = 3'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q,  state_d;
  logic [2:0]       sel_q,    sel_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             ack_q,    ack_d;
  logic             switch_q, switch_d;
  logic             armed_q,  armed_d;

  logic [2:0] sel_next;
  logic       auto_due;

  assign sel_next = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;
  // >= rather than == so a count that saturated while auto mode was off
  // still advances on the first frame after auto mode is enabled.
  assign auto_due = auto_en && (cnt_q >= HOLD_LAST);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    switch_d = 1'b0;
    // A held request re-arms only once it has been seen low, so one press
    // can never produce two advances.
    armed_d  = armed_q | ~next_req;

    case (state_q)
      S_SYNC: begin
        if (frame_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        if (frame_start) begin
          if (auto_due) begin
            sel_d    = sel_next;
            cnt_d    = '0;
            switch_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Accepting a request is independent of the frame edge: if an auto
        // advance fires in the same cycle, the manual one follows next frame.
        if (next_req && armed_q) begin
          ack_d   = 1'b1;
          armed_d = 1'b0;
          state_d = S_PEND;
        end
      end

      S_PEND: begin
        // One advance only, even if the auto terminal count coincides.
        if (frame_start) begin
          sel_d    = sel_next;
          cnt_d    = '0;
          switch_d = 1'b1;
          state_d  = S_RUN;
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q  <= S_SYNC;
      sel_q    <= 3'd0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      switch_q <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      switch_q <= switch_d;
      armed_q  <= armed_d;
    end
  end

  assign next_ack       = ack_q;
  assign pattern_sel    = sel_q;
  assign pattern_switch = switch_q;
  assign frame_cnt      = cnt_q;
  assign busy           = (state_q == S_PEND);

endmodule
